packet_sink: RTL

Terminal consumer for the two-phase (toggle) req/ack flit link driven by the packet source. Acknowledges every flit, reassembles FLITS-flit packets framed by the head bit (data MSB), checks framing, and reports completed packets, a packet count and a sticky error flag. Sits at the far end of the link in every NoC test bench and acts as the traffic scoreboard's input.

---
 rtl/packet_sink_pkg.sv | 28 ++
 rtl/packet_sink_toggle_detect.sv | 20 ++
 rtl/packet_sink.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/packet_sink_pkg.sv
// Shared types and framing helpers for the two-phase flit sink.
// The head marker is the flit MSB; classification depends on whether a packet is in progress.
package packet_sink_pkg;

   typedef enum logic {
      IDLE,
      HOLD
   } sink_state_e;

   typedef enum logic [1:0] {
      FLIT_HEAD,
      FLIT_BODY,
      FLIT_STRAY_BODY,
      FLIT_EARLY_HEAD
   } flit_kind_e;

   localparam int unsigned COUNT_W = 8;
   localparam int unsigned DELAY_W = 4;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   function automatic flit_kind_e classify_flit(input logic head, input logic at_start);
      if (at_start)
         return head ? FLIT_HEAD : FLIT_STRAY_BODY;
      else
         return head ? FLIT_EARLY_HEAD : FLIT_BODY;
   endfunction

endpackage

// File: rtl/packet_sink_toggle_detect.sv
// Two-phase request edge detector: remembers the last seen req level and flags any change.
module toggle_detect (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic req_event
);

   logic req_old;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         req_old <= 1'b0;
      else
         req_old <= req;
   end

   assign req_event = req ^ req_old;

endmodule

// File: rtl/packet_sink.sv
// Terminal consumer of the toggle req/ack flit link: acks every flit, reassembles
// head-framed packets, counts completed packets and keeps a sticky error flag.
module packet_sink
   import packet_sink_pkg::*;
#(
   parameter int          ID        = 0,
   parameter int unsigned FLITS     = 8,
   parameter int unsigned SIZE      = 8,
   parameter int unsigned PACKETS   = 2,
   parameter int unsigned ACK_DELAY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [SIZE-1:0]       data,
   output logic                  ack,
   output logic                  pkt_valid,
   output logic [FLITS*SIZE-1:0] pkt_data,
   output logic [COUNT_W-1:0]    packet_count,
   output logic                  error,
   output logic                  done
);

   localparam int unsigned        HEAD_BIT  = SIZE - 1;
   localparam logic [7:0]         LAST_IDX  = 8'(FLITS - 1);
   localparam logic [DELAY_W-1:0] HOLD_LOAD = (ACK_DELAY == 0) ? '0 : DELAY_W'(ACK_DELAY - 1);
   // An out-of-range configuration shows up as a permanently raised error flag.
   localparam bit CFG_BAD = (ID < 0) || (FLITS < 1) || (FLITS > 255) || (SIZE < 1) ||
                            (PACKETS < 1) || (PACKETS > 255) || (ACK_DELAY > 15);

   sink_state_e          state, state_n;
   logic [DELAY_W-1:0]   hold_cnt, hold_cnt_n;
   logic                 req_event;
   logic                 accept;
   logic                 ack_fire;
   logic                 hold_violation;

   logic [7:0]           flit_idx;
   logic [FLITS*SIZE-1:0] buffer;
   logic [FLITS*SIZE-1:0] assembled;
   logic                 error_q;
   logic                 complete;
   flit_kind_e           kind;

   toggle_detect u_toggle_detect (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_event (req_event)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   always_comb begin
      state_n        = state;
      hold_cnt_n     = hold_cnt;
      accept         = 1'b0;
      ack_fire       = 1'b0;
      hold_violation = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_event) begin
               accept = 1'b1;
               if (ACK_DELAY == 0) begin
                  ack_fire = 1'b1;
               end else begin
                  state_n    = HOLD;
                  hold_cnt_n = HOLD_LOAD;
               end
            end
         end
         HOLD: begin
            // The source must wait for ack; any new toggle here is dropped as a violation.
            hold_violation = req_event;
            if (hold_cnt == '0) begin
               ack_fire = 1'b1;
               state_n  = IDLE;
            end else begin
               hold_cnt_n = hold_cnt - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign kind     = classify_flit(data[HEAD_BIT], flit_idx == '0);
   assign complete = accept && (kind == FLIT_HEAD || kind == FLIT_BODY) && (flit_idx == LAST_IDX);

   always_comb begin
      assembled = buffer;
      assembled[(FLITS-1)*SIZE +: SIZE] = data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack          <= 1'b0;
         pkt_valid    <= 1'b0;
         pkt_data     <= '0;
         packet_count <= '0;
         error_q      <= 1'b0;
         flit_idx     <= '0;
         buffer       <= '0;
      end else begin
         pkt_valid <= complete;
         if (ack_fire)
            ack <= ~ack;
         if (hold_violation ||
             (accept && (done || kind == FLIT_STRAY_BODY || kind == FLIT_EARLY_HEAD)))
            error_q <= 1'b1;
         if (accept) begin
            if (kind == FLIT_EARLY_HEAD) begin
               // Restart framing with this head as slot 0 of a fresh packet.
               buffer[SIZE-1:0] <= data;
               flit_idx         <= 8'd1;
            end else if (kind != FLIT_STRAY_BODY) begin
               for (int unsigned i = 0; i < FLITS; i++)
                  if (flit_idx == 8'(i))
                     buffer[i*SIZE +: SIZE] <= data;
               flit_idx <= complete ? '0 : flit_idx + 8'd1;
            end
         end
         if (complete) begin
            pkt_data <= assembled;
            if (packet_count != COUNT_MAX)
               packet_count <= packet_count + 8'd1;
         end
      end
   end

   assign done  = (packet_count >= 8'(PACKETS));
   assign error = error_q | CFG_BAD;

endmodule
